gpr_wb_regfile: RTL

- Architectural 32x32 GPR file at the far end of the write-back path: consumes the per-pipe write-back triples (enable, number, data) from the primary and secondary write-back stages.
- Serves four combinational read ports to issue, with same-cycle write bypass.
- Keeps a per-register outstanding-write scoreboard (counters) so issue can detect pending writers and stall.
- Sits between issue (reads, scoreboard set) and the two write-back stages (writes, scoreboard clear).

---
 rtl/gpr_wb_regfile_pkg.sv | 11 +
 rtl/gpr_scoreboard_cnt.sv | 21 ++
 rtl/gpr_wb_regfile.sv | 88 ++++++++
 3 files changed

// File: rtl/gpr_wb_regfile_pkg.sv
// gpr_wb_regfile_pkg: shared types and sizes for the GPR write-back register file
package gpr_wb_regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    typedef logic [4:0]        GPR_NUM;
    typedef logic [DATA_W-1:0] SINGLE_WORD;
    typedef logic [CNT_W-1:0]  cnt_t;
    localparam SINGLE_WORD ZEROWORD = '0;
endpackage

// File: rtl/gpr_scoreboard_cnt.sv
// gpr_scoreboard_cnt: one register's outstanding-write counter with clamp and flush
module gpr_scoreboard_cnt
    import gpr_wb_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic [1:0] inc,
    input  logic [1:0] dec,
    output cnt_t       cnt
);
    localparam logic signed [CNT_W+1:0] MAX_S = CNT_MAX[CNT_W+1:0];
    logic signed [CNT_W+1:0] nxt;
    always_comb nxt = $signed({2'b00, cnt}) + $signed({{CNT_W{1'b0}}, inc}) - $signed({{CNT_W{1'b0}}, dec});
    always_ff @(posedge clk) begin
        if (rst || flush)
            cnt <= '0;
        else
            cnt <= nxt[CNT_W+1] ? '0 : (nxt > MAX_S) ? cnt_t'(CNT_MAX) : nxt[CNT_W-1:0];
    end
endmodule

// File: rtl/gpr_wb_regfile.sv
// gpr_wb_regfile: 32x32 GPR file with dual write-back, 4 bypassed read ports and issue scoreboard
module gpr_wb_regfile
    import gpr_wb_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wb0_en_i,
    input  GPR_NUM     wb0_num_i,
    input  SINGLE_WORD wb0_data_i,
    input  logic       wb1_en_i,
    input  GPR_NUM     wb1_num_i,
    input  SINGLE_WORD wb1_data_i,
    input  GPR_NUM     rd0_num_i,
    input  GPR_NUM     rd1_num_i,
    input  GPR_NUM     rd2_num_i,
    input  GPR_NUM     rd3_num_i,
    output SINGLE_WORD rd0_data_o,
    output SINGLE_WORD rd1_data_o,
    output SINGLE_WORD rd2_data_o,
    output SINGLE_WORD rd3_data_o,
    output logic       rd0_busy_o,
    output logic       rd1_busy_o,
    output logic       rd2_busy_o,
    output logic       rd3_busy_o,
    input  logic       iss0_fire_i,
    input  GPR_NUM     iss0_num_i,
    input  logic       iss1_fire_i,
    input  GPR_NUM     iss1_num_i,
    output logic       iss_ready_o,
    input  logic       flush_i
);
    localparam logic [CNT_W+1:0] MAX_W = CNT_MAX[CNT_W+1:0];
    SINGLE_WORD regs [NUM_REGS];
    cnt_t       cnt  [NUM_REGS];
    logic [1:0] inc  [NUM_REGS];
    logic [1:0] dec  [NUM_REGS];
    GPR_NUM     rd_num  [4];
    SINGLE_WORD rd_data [4];
    logic       rd_busy [4];
    logic       same;
    logic [CNT_W+1:0] need0, need1;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= ZEROWORD;
        end else begin
            if (wb0_en_i && wb0_num_i != '0) regs[wb0_num_i] <= wb0_data_i;
            if (wb1_en_i && wb1_num_i != '0) regs[wb1_num_i] <= wb1_data_i;
        end
    end
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = '0;
            dec[i] = '0;
            if (i != 0) begin
                inc[i] = {1'b0, iss0_fire_i && iss0_num_i == GPR_NUM'(i)} + {1'b0, iss1_fire_i && iss1_num_i == GPR_NUM'(i)};
                dec[i] = {1'b0, wb0_en_i && wb0_num_i == GPR_NUM'(i)} + {1'b0, wb1_en_i && wb1_num_i == GPR_NUM'(i)};
            end
        end
    end
    assign cnt[0] = '0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        gpr_scoreboard_cnt u_cnt (
            .clk   (clk),
            .rst   (rst),
            .flush (flush_i),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .cnt   (cnt[r])
        );
    end
    assign rd_num = '{rd0_num_i, rd1_num_i, rd2_num_i, rd3_num_i};
    // Younger write-back wins over older, both win over the array
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_data[i] = (rd_num[i] == '0) ? ZEROWORD :
                         (wb1_en_i && wb1_num_i == rd_num[i]) ? wb1_data_i :
                         (wb0_en_i && wb0_num_i == rd_num[i]) ? wb0_data_i : regs[rd_num[i]];
            rd_busy[i] = {2'b00, cnt[rd_num[i]]} > {{CNT_W{1'b0}}, dec[rd_num[i]]};
        end
    end
    assign {rd0_data_o, rd1_data_o, rd2_data_o, rd3_data_o} = {rd_data[0], rd_data[1], rd_data[2], rd_data[3]};
    assign {rd0_busy_o, rd1_busy_o, rd2_busy_o, rd3_busy_o} = {rd_busy[0], rd_busy[1], rd_busy[2], rd_busy[3]};
    // Requests are judged on the dest numbers alone so issue can gate fire on ready
    assign same  = iss0_num_i == iss1_num_i;
    assign need0 = {2'b00, cnt[iss0_num_i]} + (CNT_W+2)'(1) + (CNT_W+2)'(same);
    assign need1 = {2'b00, cnt[iss1_num_i]} + (CNT_W+2)'(1) + (CNT_W+2)'(same);
    assign iss_ready_o = !((iss0_num_i != '0 && need0 > MAX_W) || (iss1_num_i != '0 && need1 > MAX_W));
endmodule
